// File: rtl/serial_cmp_ctrl.sv
// Bit-serial MSB-first compare sequencer driving one registered 1-bit comparator.
// Stops at the first differing bit and reports gt/ls/eq/err plus the bit count.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             ls,
  output logic             eq,
  output logic             err,
  output logic [CW-1:0]    bits_used,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_ls,
  input  logic             cmp_eq,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only while busy=0; busy stays high until the
  // one-cycle done pulse, during which the result registers are valid.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAST = 2'd2, DONE = 2'd3} state_t;

  localparam logic [CW-1:0] LSB_IDX = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [CW-1:0]    cnt_q;
  logic             gt_q, ls_q, eq_q, err_q;
  logic [CW-1:0]    bits_q;
  logic             one_hot;

  // Exactly one comparator flag raised; anything else is a protocol violation.
  assign one_hot = (cmp_gt ^ cmp_ls ^ cmp_eq) & ~(cmp_gt & cmp_ls & cmp_eq);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      ls_q    <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
      bits_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q    <= op_a;
            sb_q    <= op_b;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q  <= {sa_q[WIDTH-2:0], 1'b0};
          sb_q  <= {sb_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q != '0 && !one_hot) begin
            gt_q    <= 1'b0;
            ls_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b1;
            bits_q  <= cnt_q;
            state_q <= DONE;
          end else if (cnt_q != '0 && !cmp_eq) begin
            gt_q    <= cmp_gt;
            ls_q    <= cmp_ls;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            bits_q  <= cnt_q;
            state_q <= DONE;
          end else if (cnt_q == LSB_IDX) begin
            state_q <= LAST;
          end
        end
        LAST: begin
          gt_q    <= one_hot & cmp_gt;
          ls_q    <= one_hot & cmp_ls;
          eq_q    <= one_hot & cmp_eq;
          err_q   <= ~one_hot;
          bits_q  <= CW'(WIDTH);
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cmp_a     = (state_q == RUN) ? sa_q[WIDTH-1] : 1'b0;
  assign cmp_b     = (state_q == RUN) ? sb_q[WIDTH-1] : 1'b0;
  assign gt        = gt_q;
  assign ls        = ls_q;
  assign eq        = eq_q;
  assign err       = err_q;
  assign bits_used = bits_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl: vector table of compares plus hand sequences for
// reset, busy-start rejection, back-to-back start, mid-op reset and comparator faults.
module tb_serial_cmp_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          busy, done, gt, ls, eq, err;
  logic [CW-1:0] bits_used;
  logic          cmp_a, cmp_b;
  logic          cmp_gt, cmp_ls, cmp_eq;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  int inj_mode = 0;  // 0 normal, 1 gt+ls both set, 2 no flag set

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .gt(gt), .ls(ls), .eq(eq), .err(err),
    .bits_used(bits_used), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_gt(cmp_gt), .cmp_ls(cmp_ls), .cmp_eq(cmp_eq), .dbg_state(dbg_state)
  );

  // Registered 1-bit comparator model with fault injection.
  always_ff @(posedge clk) begin
    if (inj_mode == 1) begin
      cmp_gt <= 1'b1; cmp_ls <= 1'b1; cmp_eq <= 1'b0;
    end else if (inj_mode == 2) begin
      cmp_gt <= 1'b0; cmp_ls <= 1'b0; cmp_eq <= 1'b0;
    end else begin
      cmp_gt <= cmp_a & ~cmp_b;
      cmp_ls <= ~cmp_a & cmp_b;
      cmp_eq <= (cmp_a == cmp_b);
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_result(input string tag, input int e_gt, input int e_ls,
                            input int e_eq, input int e_err, input int e_bits);
    chk({tag, " gt"}, gt, e_gt);
    chk({tag, " ls"}, ls, e_ls);
    chk({tag, " eq"}, eq, e_eq);
    chk({tag, " err"}, err, e_err);
    chk({tag, " bits_used"}, bits_used, e_bits);
  endtask

  // ---------------- driver ----------------
  // Pulses start for one cycle T, then scrambles operands; returns the k at
  // whose cycle T+k done was first seen (-1 if none within budget).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] ca,
                        output logic [W-1:0] cb, output int busy_low);
    lat = -1; ca = '0; cb = '0; busy_low = 0;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 1'b0; op_a = ~a; op_b = ~b;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= W) begin
        ca[W-k] = cmp_a;
        cb[W-k] = cmp_b;
      end
      if (!busy) busy_low++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int gt, ls, eq, bits, lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, busy_low, done_cnt;
    logic [W-1:0] ca, cb;

    vecs[0] = '{8'hA5, 8'hA5, 0, 0, 1, 8, 10};
    vecs[1] = '{8'h80, 8'h7F, 1, 0, 0, 1, 3};
    vecs[2] = '{8'h10, 8'h11, 0, 1, 0, 8, 10};
    vecs[3] = '{8'h0C, 8'h08, 1, 0, 0, 6, 8};
    vecs[4] = '{8'h00, 8'hFF, 0, 1, 0, 1, 3};
    vecs[5] = '{8'h55, 8'h54, 1, 0, 0, 8, 10};
    vecs[6] = '{8'h40, 8'h60, 0, 1, 0, 3, 5};
    vecs[7] = '{8'hFF, 8'hFF, 0, 0, 1, 8, 10};
    vecs[8] = '{8'h00, 8'h00, 0, 0, 1, 8, 10};
    vecs[9] = '{8'h3C, 8'h2C, 1, 0, 0, 4, 6};

    // Reset held with start asserted: everything stays zero.
    start = 1'b1; op_a = 8'hF0; op_b = 8'h0F;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset cmp_a", cmp_a, 0);
      chk("reset cmp_b", cmp_b, 0);
      chk_result("reset", 0, 0, 0, 0, 0);
    end
    chk("reset state", dbg_state, 0);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle after reset busy", busy, 0);

    // Table-driven compares.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, ca, cb, busy_low);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d busy gaps", i), busy_low, 0);
      chk_result($sformatf("v%0d", i), vecs[i].gt, vecs[i].ls, vecs[i].eq, 0, vecs[i].bits);
      if (vecs[i].bits == W) begin
        chk($sformatf("v%0d cmp_a seq", i), ca, vecs[i].a);
        chk($sformatf("v%0d cmp_b seq", i), cb, vecs[i].b);
      end
      @(negedge clk);
      chk($sformatf("v%0d done one cycle", i), done, 0);
      chk($sformatf("v%0d idle busy", i), busy, 0);
    end

    // Results held across idle cycles.
    run_op(8'h80, 8'h7F, lat, ca, cb, busy_low);
    repeat (4) @(negedge clk);
    chk_result("hold", 1, 0, 0, 0, 1);

    // Start while busy (T+3) and during DONE ignored; start at T+9 accepted.
    @(negedge clk);
    start = 1'b1; op_a = 8'h0C; op_b = 8'h08;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 8 || k == 9);
      op_a = 8'h00; op_b = 8'hFF;
      if (done && lat < 0) lat = k;
      if (k == 9) break;
    end
    chk("busy-start latency", lat, 8);
    chk("busy-start gt", gt, 1);
    chk("busy-start bits", bits_used, 6);
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    chk("b2b latency", lat, 3);
    chk_result("b2b", 0, 1, 0, 0, 1);

    // Reset mid-operation: no done, results cleared.
    @(negedge clk);
    start = 1'b1; op_a = 8'h10; op_b = 8'h11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort cmp_a", cmp_a, 0);
    chk_result("abort", 0, 0, 0, 0, 0);
    rst = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort no done", done_cnt, 0);

    // Comparator faults.
    inj_mode = 1;
    run_op(8'h33, 8'h33, lat, ca, cb, busy_low);
    chk("err both latency", lat, 3);
    chk_result("err both", 0, 0, 0, 1, 1);
    inj_mode = 2;
    run_op(8'h33, 8'h33, lat, ca, cb, busy_low);
    chk("err none latency", lat, 3);
    chk_result("err none", 0, 0, 0, 1, 1);
    inj_mode = 0;
    run_op(8'h01, 8'h02, lat, ca, cb, busy_low);
    chk("recover latency", lat, 9);
    chk_result("recover", 0, 1, 0, 0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
Sequencer that drives the team's registered 1-bit comparator bit-serially over two WIDTH-bit operands, MSB first. It stops early at the first differing bit and reports gt/ls/eq, the number of bits examined, and a protocol-error flag. The block sits between a requesting unit and one comparator instance, using a start/busy/done handshake.

Parameters:
WIDTH, 8, operand width in bits (>= 2)
CW, $clog2(WIDTH+1), width of bits_used (4 for WIDTH=8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
start  in  1  request; sampled only in IDLE
op_a  in  WIDTH  operand A; latched when start is accepted
op_b  in  WIDTH  operand B; latched when start is accepted
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; results valid in this cycle
gt  out  1  A > B
ls  out  1  A < B
eq  out  1  A == B
err  out  1  comparator protocol violation detected
bits_used  out  CW  bits examined, 1..WIDTH
cmp_a  out  1  bit driven to comparator input a
cmp_b  out  1  bit driven to comparator input b
cmp_gt  in  1  comparator gt
cmp_ls  in  1  comparator ls
cmp_eq  in  1  comparator eq

Behaviour:
- Comparator contract: registered. Bits driven in cycle k appear on cmp_* in cycle k+1.
- Reset (rst=0 at a clock edge): state IDLE. All outputs 0, including cmp_a/cmp_b. Shift registers and counter are cleared. Applies from any state; an aborted operation produces no done.
- States:
  - IDLE: cmp_a/cmp_b=0. If start=1: latch op_a/op_b into shift regs sa/sb, set cnt=0, go to RUN.
  - RUN: drive cmp_a=sa[WIDTH-1], cmp_b=sb[WIDTH-1], shift both left, cnt++.
    - If cnt>=1 (prior bit pending), sample cmp_*:
      - exactly one of gt/ls set → record it, bits_used=cnt, go to DONE.
      - zero or more than one flag set → err=1, gt/ls/eq=0, bits_used=cnt, go to DONE.
    - Otherwise, if the bit driven this cycle is the LSB (cnt==WIDTH-1 before increment), go to LAST.
  - LAST: cmp_a/cmp_b=0. Sample result of the LSB: gt, ls or eq recorded (same error rule), bits_used=WIDTH. Go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Result regs (gt, ls, eq, err, bits_used):
  - Written only on the transition into DONE.
  - Held until the next DONE.
  - Not cleared at start.
- Latency: start accepted at cycle T; first differing bit at MSB-relative position j (0=MSB). Done pulses at T+3+j. Equal operands give done at T+WIDTH+2.
- Simultaneous/boundary:
  - start while busy (including the DONE cycle) is ignored.
  - op_a/op_b changes after acceptance have no effect.
  - Back-to-back: earliest next acceptance is the cycle after DONE.
- Exactly one of gt/ls/eq/err is 1 after any completed operation.

Test Plan:
(WIDTH=8; start pulsed one cycle at T; comparator modelled as registered 1-bit compare)
1. rst=0 for 2 cycles, start=1 held → busy=done=gt=ls=eq=err=0, bits_used=0, cmp_a=cmp_b=0. No start accepted until rst=1.
2. op_a=0xA5, op_b=0xA5 → cmp_a sequence 1,0,1,0,0,1,0,1 over T+1..T+8. done at T+10 with eq=1, gt=ls=err=0, bits_used=8.
3. op_a=0x80, op_b=0x7F → done at T+3, gt=1, bits_used=1, busy high T+1..T+3. Results held after done while start=0.
4. op_a=0x10, op_b=0x11 → done at T+10, ls=1, bits_used=8 (LSB decides via LAST).
5. op_a=0x0C, op_b=0x08; second start with op_a=0x00, op_b=0xFF at T+3 → second start ignored. done at T+8 only, gt=1, bits_used=6. A start at T+9 is accepted.
6. Two cases:
   - rst=0 at T+4 during a compare → IDLE at T+5, no done pulse, outputs 0.
   - Comparator model forces cmp_gt=cmp_ls=1 at first sample → done at T+3, err=1, gt=ls=eq=0, bits_used=1.
